// File: rtl/deskew_collect.sv
// Removes the diagonal skew from systolic-array result rows and collects DIM
// aligned rows into a buffer that is drained in order over a valid/ready stream.
module deskew_lane #(
  parameter int W      = 24,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else if (shift) begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[STAGES-1];
endmodule

module deskew_collect #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                clr,
  input  logic                                in_valid,
  input  logic signed [DIM-1:0][BITS_C-1:0]   din,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DIM-1:0][BITS_C-1:0]   out_data,
  output logic [$clog2(DIM)-1:0]              out_idx,
  output logic                                full,
  output logic                                overflow
);
  localparam int PW = $clog2(DIM);
  localparam logic [PW-1:0] LAST = PW'(DIM-1);

  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DIM-2:0]                       vld_pipe;
  logic [DIM-1:0][BITS_C-1:0]           row;
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0]  row_buf;
  logic [PW-1:0]                        wr_ptr, rd_ptr;
  logic                                 aligned, wr_row, drop_row, hs, shift;

  // clr freezes the delay lines so their data is left untouched
  assign shift = en && !clr;

  for (genvar j = 0; j < DIM-1; j++) begin : g_lane
    deskew_lane #(.W(BITS_C), .STAGES(DIM-1-j)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .shift (shift),
      .d     (din[j]),
      .q     (row[j])
    );
  end
  assign row[DIM-1] = din[DIM-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_pipe <= '0;
    else if (clr) vld_pipe <= '0;
    else if (en) begin
      vld_pipe[0] <= in_valid;
      for (int i = 1; i < DIM-1; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign aligned = en && vld_pipe[DIM-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = COLLECT;
    else begin
      case (state)
        COLLECT: if (aligned && wr_ptr == LAST)   state_nxt = DRAIN;
        DRAIN:   if (out_ready && rd_ptr == LAST) state_nxt = COLLECT;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == DRAIN);
    full      = (state == DRAIN);
    wr_row    = aligned && (state == COLLECT);
    drop_row  = aligned && (state == DRAIN);
    hs        = (state == DRAIN) && out_ready;
    out_data  = row_buf[rd_ptr];
    out_idx   = rd_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_row)   wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (hs)       rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (drop_row) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  row_buf         <= '0;
    else if (wr_row && !clr)  row_buf[wr_ptr] <= row;
  end
endmodule

// File: tb/tb_deskew_collect.sv
// Random-data bench for deskew_collect: a row-level model predicts which rows
// land in each batch; a negedge monitor checks flags and every drained row.
module tb_deskew_collect;
  localparam int DIM = 8, BITS_C = 24;
  typedef logic [DIM-1:0][BITS_C-1:0] row_t;
  typedef struct { int id; int rem; } fl_t;

  logic clk = 0, rst = 0, en = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic signed [DIM-1:0][BITS_C-1:0] din = '0, out_data;
  logic out_valid, full, overflow;
  logic [2:0] out_idx;

  deskew_collect #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int   errors = 0, checks = 0;
  row_t rowdat [0:127];
  int   issued [0:8191];
  int   k = 0, cur_id = 0;
  fl_t  pend[$];
  row_t exp_q[$];
  int   m_cnt = 0, m_rd = 0;
  bit   m_full = 0, m_ovf = 0;
  bit   hold = 0;
  row_t hdata;
  logic [2:0] hidx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_row(input string nm, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // en-edge counter used to schedule the skewed lanes
  always @(posedge clk) if (en) k++;

  // Row-level reference: a row issued at en-edge E aligns at en-edge E+DIM-1;
  // it joins the batch unless the batch is full, in which case it is lost.
  always @(posedge clk or posedge rst) begin : model
    bit f0;
    int got;
    if (rst || clr) begin
      pend.delete(); exp_q.delete();
      m_cnt = 0; m_rd = 0; m_full = 0; m_ovf = 0;
    end else begin
      f0  = m_full;
      got = -1;
      if (en) begin
        foreach (pend[i]) pend[i].rem = pend[i].rem - 1;
        if (pend.size() > 0 && pend[0].rem == 0) got = pend.pop_front().id;
        if (in_valid) pend.push_back('{cur_id, DIM-1});
      end
      if (got >= 0) begin
        if (f0) m_ovf = 1;
        else begin
          exp_q.push_back(rowdat[got]);
          m_cnt++;
          if (m_cnt == DIM) begin m_cnt = 0; m_full = 1; end
        end
      end
      if (f0 && out_ready) begin
        m_rd++;
        if (m_rd == DIM) begin m_rd = 0; m_full = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) hold = 0;
    else begin
      chk("full", full, m_full);
      chk("out_valid", out_valid, m_full);
      chk("overflow", overflow, m_ovf);
      if (out_valid) chk("out_idx", out_idx, m_rd);
      if (hold && out_valid) begin
        chk_row("hold_data", out_data, hdata);
        chk("hold_idx", out_idx, hidx);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("row_expected", 1, 0);
        else chk_row("row_data", out_data, exp_q.pop_front());
      end
      hold  = out_valid && !out_ready;
      hdata = out_data;
      hidx  = out_idx;
    end
  end

  task automatic set_din();
    for (int j = 0; j < DIM; j++) begin
      int idx;
      idx = k - j;
      if (idx >= 0 && issued[idx] >= 0) din[j] = rowdat[issued[idx]][j];
      else din[j] = {k[15:0], 4'(j), 4'h5};
    end
  endtask

  task automatic tick(input bit e);
    en = e;
    set_din();
    @(posedge clk); #2;
  endtask

  task automatic send(input int id, input int lead);
    in_valid = 0;
    for (int i = 0; i < lead; i++) tick(0);
    issued[k] = id; cur_id = id; in_valid = 1;
    tick(1);
    in_valid = 0;
  endtask

  task automatic idle(input int n, input bit gap);
    for (int i = 0; i < n; i++) tick(gap ? bit'(i % 2) : 1'b1);
  endtask

  task automatic wait_full();
    for (int n = 0; n < 100 && !full; n++) tick(1);
    chk("full_reached", full, 1);
  endtask

  task automatic drain(input int mode);
    int n;
    n = 0;
    while (full && n < 300) begin
      case (mode)
        0: out_ready = 1;
        1: out_ready = (n % 4 == 0) || (n % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      tick(1);
      n++;
    end
    out_ready = 0;
    chk("drain_done", full, 0);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0; clr = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_data", (out_data == '0), 1);
    @(posedge clk); #2;
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) issued[i] = -1;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < DIM; j++)
        rowdat[i][j] = (i < 16) ? BITS_C'(16 * (i % 8) + j) : BITS_C'($urandom());

    #1 do_reset();

    // back-to-back batch, full-rate drain
    for (int r = 0; r < 8; r++) send(r, 0);
    wait_full();
    drain(0);

    // same rows with en toggling
    for (int r = 8; r < 16; r++) send(r, 1);
    idle(DIM + 4, 1);
    wait_full();
    drain(0);

    // backpressure pattern during drain
    for (int r = 16; r < 24; r++) send(r, 0);
    wait_full();
    drain(1);

    // a ninth row aligns while full and is dropped
    for (int r = 24; r < 33; r++) send(r, 0);
    idle(10, 0);
    chk("overflow_set", overflow, 1);
    drain(0);
    chk("overflow_sticky", overflow, 1);
    clr = 1; tick(1); clr = 0;
    chk("overflow_clr", overflow, 0);

    // reset after partial collection, then mid-drain
    for (int r = 33; r < 38; r++) send(r, 0);
    idle(10, 0);
    do_reset();
    for (int r = 38; r < 46; r++) send(r, 0);
    wait_full();
    begin
      int n;
      n = 0;
      out_ready = 1;
      while (out_idx != 3 && n < 50) begin tick(1); n++; end
      out_ready = 0;
      chk("reached_idx3", out_idx, 3);
    end
    do_reset();
    for (int r = 46; r < 54; r++) send(r, 0);
    wait_full();
    drain(2);

    // clr while a row is in flight
    send(54, 0);
    tick(1); tick(1);
    clr = 1; tick(1); clr = 0;
    idle(12, 0);
    chk("clr_no_full", full, 0);
    for (int r = 55; r < 63; r++) send(r, $urandom_range(0, 2));
    for (int i = 0; i < 12; i++) tick(1'($urandom_range(0, 1)));
    wait_full();
    drain(2);

    idle(4, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/deskew_collect.md
# deskew_collect

Output-side companion of the skewed row feeder in front of the systolic array. The array emits result rows as a diagonal wavefront: lane j of row r arrives j enable-cycles after lane 0. This block removes that skew with per-lane delay lines and gathers DIM aligned rows into a row buffer. It then drains the rows, in order, over a valid/ready stream to the host-side readback logic.

## Interface
- BITS_C, 24, signed width of one result element
- DIM, 8, lanes per row and rows per batch; legal values are DIM ≥ 2
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- en  input  1  advance enable; all delay lines and the valid pipe shift only on edges where en=1
- clr  input  1  synchronous abort: empties the valid pipe, zeroes the pointers and overflow, returns to COLLECT
- in_valid  input  1  lane 0 of din holds the first element of a new row this en-cycle
- din  input  [DIM-1:0][BITS_C-1:0] signed  skewed lane data
- out_valid  output  1  out_data holds a buffered row
- out_ready  input  1  consumer accepts the row
- out_data  output  [DIM-1:0][BITS_C-1:0] signed  aligned row; element j comes from lane j
- out_idx  output  $clog2(DIM)  row index of out_data within the batch
- full  output  1  state is DRAIN
- overflow  output  1  sticky; an aligned row arrived while in DRAIN and was dropped

## Operation
- Deskew:
  - Lane j passes through a shift register of DIM-1-j stages, clocked by en.
  - Lane DIM-1 is taken directly from din.
  - A DIM-1 stage valid pipe carries in_valid alongside lane 0.
- Aligned row: the valid-pipe tail is 1 and en=1. At that edge the delay outputs, plus din[DIM-1], form row r.
- Row buffer: DIM entries. wr_ptr and rd_ptr each count 0..DIM-1.
- FSM COLLECT (reset state):
  - Each aligned row is written to buf[wr_ptr], and wr_ptr increments.
  - On the edge that writes entry DIM-1, wr_ptr wraps to 0 and the state goes to DRAIN.
- FSM DRAIN:
  - out_valid=1 and out_data=buf[rd_ptr]; out_idx=rd_ptr.
  - Each edge with out_valid && out_ready increments rd_ptr.
  - The handshake on index DIM-1 wraps rd_ptr to 0 and returns the state to COLLECT.
- Aligned row during DRAIN: the row is not written, overflow is set, and wr_ptr is unchanged.
- The deskew path keeps shifting in every state. Rows already in flight still complete, and are counted or dropped per the rule above.
- en=0: the delay lines and valid pipe freeze. The drain handshake is independent of en.
- Simultaneous aligned row and last drain handshake: the state is DRAIN at that edge, so the row is dropped and overflow is set.
- clr has priority over every event except rst.
  - It zeroes the valid pipe, wr_ptr, rd_ptr and overflow, and forces COLLECT.
  - Delay-line data and buffer contents are left unchanged.
- Arithmetic: none on data. Values pass bit-exact.

## Timing
- Reset values: out_valid=0, out_idx=0, out_data=0 (buffer and delay lines zeroed), full=0, overflow=0, state COLLECT, both pointers 0.
- Deskew latency: row r with in_valid at en-edge E is written at en-edge E+DIM-1. This equals DIM-1 clocks if en is held high.
- full and out_valid rise in the cycle after the edge that writes the DIM-th row.
- out_valid and out_data are registered state. They are stable while out_ready=0.
- Full-rate drain: DIM consecutive cycles with out_ready=1 empty the buffer. full and out_valid fall in the cycle after the last handshake.
- Throughput: one row per en-cycle in; one row per cycle out.
- Reset mid-DRAIN: out_valid drops immediately (asynchronously). Rows in the buffer are lost.

## Test plan
- DIM=8, BITS_C=24, en held high.
  - Stimulus: 8 rows back-to-back, skewed, with element (r,j)=16·r+j, then out_ready=1.
  - Required: full rises 8 cycles after the last in_valid. out_idx reads 0..7 and out_data[j]=16·out_idx+j on 8 consecutive cycles. full then falls.
- en gaps:
  - Stimulus: same 8 rows, with en deasserted on alternate cycles while din is held.
  - Required: identical buffered contents, and each row write occurs exactly 7 en-edges after its in_valid.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeatedly during drain.
  - Required: out_data and out_idx hold steady while out_ready=0. Rows 0..7 each appear exactly once, in order, with no loss.
- Overflow:
  - Stimulus: a 9th row injected so that it aligns while full=1.
  - Required: the row is dropped and overflow=1 stays set through the drain. clr clears overflow to 0 one cycle later.
- Reset mid-operation:
  - Stimulus: rst asserted after 5 rows collected and again at out_idx=3 in drain.
  - Required: every output returns to its reset value without waiting for a clock edge. The following batch of 8 rows is collected correctly from index 0.
- clr with rows in flight:
  - Stimulus: clr pulsed 3 cycles after an in_valid.
  - Required: that row is never written, wr_ptr stays 0 and full stays 0.
